// File: rtl/dcache_responder_pkg.sv
`default_nettype none
// ============================================================================
// Package : lc3b_types
// Purpose : Shared LC-3b types plus the D-cache additions: line, tag and
//           index types for the default 3-bit index, the D-cache FSM state
//           enum, and a byte-lane merge helper for store hits.
// Revision: 1.0 - initial D-cache types
// ============================================================================
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [1:0]   lc3b_mem_wmask;

    typedef logic [127:0] lc3b_c_line;

    localparam int C_S_INDEX = 3;
    typedef logic [C_S_INDEX-1:0]  lc3b_c_index;
    typedef logic [11-C_S_INDEX:0] lc3b_c_tag;

    typedef enum logic [1:0] {
        s_idle      = 2'd0,
        s_resp      = 2'd1,
        s_writeback = 2'd2,
        s_fill      = 2'd3
    } dcache_state_t;

    // Replace the enabled bytes of word 'wsel' in 'line' with 'wdata'.
    // A zero mask returns the line unchanged.
    function automatic lc3b_c_line merge_word(
        input lc3b_c_line    line,
        input logic [2:0]    wsel,
        input lc3b_word      wdata,
        input lc3b_mem_wmask be
    );
        lc3b_c_line r;
        r = line;
        if (be[0]) r[{wsel, 4'd0} +: 8] = wdata[7:0];
        if (be[1]) r[{wsel, 4'd8} +: 8] = wdata[15:8];
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_responder_array.sv
`default_nettype none
// ============================================================================
// Module  : cache_array
// Purpose : Per-set storage of WIDTH bits, 2**S_INDEX entries. Combinational
//           read of the addressed entry, synchronous write on 'load'.
//           With CLEAR=1 a low 'reset' zeroes every entry (valid/dirty bits);
//           with CLEAR=0 contents survive reset (tags, line data).
// Ports   : clk   - clock, rising edge
//           reset - synchronous, active-low
//           load  - write 'in' into entry 'index'
//           index - set select
//           in    - write data
//           out   - read data of entry 'index'
// Revision: 1.0 - initial release
// ============================================================================
module cache_array #(
    parameter int WIDTH   = 1,
    parameter int S_INDEX = 3,
    parameter bit CLEAR   = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [S_INDEX-1:0] index,
    input  logic [WIDTH-1:0]   in,
    output logic [WIDTH-1:0]   out
);

    localparam int DEPTH = 2 ** S_INDEX;

    logic [WIDTH-1:0] data_q [DEPTH];

    generate
        if (CLEAR) begin : g_clear
            always_ff @(posedge clk) begin
                if (!reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        data_q[i] <= '0;
                    end
                end else if (load) begin
                    data_q[index] <= in;
                end
            end
        end else begin : g_noclear
            logic w_unused_reset;
            assign w_unused_reset = reset;

            always_ff @(posedge clk) begin
                if (load) begin
                    data_q[index] <= in;
                end
            end
        end
    endgenerate

    assign out = data_q[index];

endmodule
`default_nettype wire

// File: rtl/dcache_responder.sv
`default_nettype none
// ============================================================================
// Module  : dcache_responder
// Purpose : Direct-mapped write-back data cache answering the pipeline's
//           D-side port. Hits complete in two cycles; misses optionally write
//           back the dirty victim, fill the line from physical memory, then
//           re-evaluate as a hit.
// Ports   : clk, reset (sync, active-low)
//           mem_address/mem_read/mem_write/mem_byte_enable/mem_wdata  - request
//           mem_rdata/mem_resp                                         - reply
//           pmem_address/pmem_read/pmem_write/pmem_wdata               - burst req
//           pmem_rdata/pmem_resp                                       - burst reply
// Revision: 1.0 - initial release
// ============================================================================
module dcache_responder
    import lc3b_types::*;
#(
    parameter int s_index = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [15:0]   mem_address,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic [1:0]    mem_byte_enable,
    input  logic [15:0]   mem_wdata,
    output logic [15:0]   mem_rdata,
    output logic          mem_resp,
    output logic [15:0]   pmem_address,
    output logic          pmem_read,
    output logic          pmem_write,
    output logic [127:0]  pmem_wdata,
    input  logic [127:0]  pmem_rdata,
    input  logic          pmem_resp
);

    localparam int TAG_W = 12 - s_index;

    dcache_state_t state_q, state_d;
    lc3b_word      rdata_q, rdata_d;

    logic [s_index-1:0] idx;
    logic [TAG_W-1:0]   req_tag;
    logic [2:0]         wsel;
    logic               req;
    logic               hit;

    logic               valid_out, dirty_out;
    logic [TAG_W-1:0]   tag_out;
    lc3b_c_line         line_out;

    logic               valid_load, valid_in;
    logic               dirty_load, dirty_in;
    logic               tag_load;
    logic               data_load;
    lc3b_c_line         data_in;

    // Offset bit 0 has no meaning for a word-wide port.
    logic w_unused_addr0;
    assign w_unused_addr0 = mem_address[0];

    assign idx     = mem_address[3+s_index:4];
    assign req_tag = mem_address[15:4+s_index];
    assign wsel    = mem_address[3:1];
    assign req     = mem_read | mem_write;
    assign hit     = valid_out && (tag_out == req_tag);

    cache_array #(.WIDTH(1), .S_INDEX(s_index), .CLEAR(1'b1)) u_valid (
        .clk(clk), .reset(reset), .load(valid_load), .index(idx),
        .in(valid_in), .out(valid_out)
    );

    cache_array #(.WIDTH(1), .S_INDEX(s_index), .CLEAR(1'b1)) u_dirty (
        .clk(clk), .reset(reset), .load(dirty_load), .index(idx),
        .in(dirty_in), .out(dirty_out)
    );

    // Tag and data writes are gated by reset so a pmem_resp coinciding with
    // reset cannot leave a half-installed line behind.
    cache_array #(.WIDTH(TAG_W), .S_INDEX(s_index), .CLEAR(1'b0)) u_tag (
        .clk(clk), .reset(reset), .load(tag_load & reset), .index(idx),
        .in(req_tag), .out(tag_out)
    );

    cache_array #(.WIDTH(128), .S_INDEX(s_index), .CLEAR(1'b0)) u_data (
        .clk(clk), .reset(reset), .load(data_load & reset), .index(idx),
        .in(data_in), .out(line_out)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= s_idle;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rdata_d      = rdata_q;
        valid_load   = 1'b0;
        valid_in     = 1'b0;
        dirty_load   = 1'b0;
        dirty_in     = 1'b0;
        tag_load     = 1'b0;
        data_load    = 1'b0;
        data_in      = line_out;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;

        unique case (state_q)
            s_idle: begin
                if (req) begin
                    if (hit) begin
                        // Write wins when both strobes are high.
                        if (mem_write) begin
                            if (mem_byte_enable != 2'b00) begin
                                data_load  = 1'b1;
                                data_in    = merge_word(line_out, wsel, mem_wdata, mem_byte_enable);
                                dirty_load = 1'b1;
                                dirty_in   = 1'b1;
                            end
                        end else begin
                            rdata_d = line_out[{wsel, 4'd0} +: 16];
                        end
                        state_d = s_resp;
                    end else if (valid_out && dirty_out) begin
                        state_d = s_writeback;
                    end else begin
                        state_d = s_fill;
                    end
                end
            end

            s_resp: begin
                state_d = s_idle;
            end

            s_writeback: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_out, idx, 4'b0000};
                pmem_wdata   = line_out;
                if (pmem_resp) begin
                    dirty_load = 1'b1;
                    dirty_in   = 1'b0;
                    state_d    = s_fill;
                end
            end

            s_fill: begin
                pmem_read    = 1'b1;
                pmem_address = {req_tag, idx, 4'b0000};
                if (pmem_resp) begin
                    data_load  = 1'b1;
                    data_in    = pmem_rdata;
                    tag_load   = 1'b1;
                    valid_load = 1'b1;
                    valid_in   = 1'b1;
                    dirty_load = 1'b1;
                    dirty_in   = 1'b0;
                    state_d    = s_idle;
                end
            end

            default: state_d = s_idle;
        endcase
    end

    assign mem_resp  = (state_q == s_resp);
    assign mem_rdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dcache_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_dcache_responder
// Purpose : Self-checking bench. A set-level cache model and a sparse line
//           memory predict read data, victim traffic and latency for each
//           access; directed scenarios are followed by randomized traffic.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dcache_responder;

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   mem_address;
    logic          mem_read;
    logic          mem_write;
    logic [1:0]    mem_byte_enable;
    logic [15:0]   mem_wdata;
    logic [15:0]   mem_rdata;
    logic          mem_resp;
    logic [15:0]   pmem_address;
    logic          pmem_read;
    logic          pmem_write;
    logic [127:0]  pmem_wdata;
    logic [127:0]  pmem_rdata;
    logic          pmem_resp;

    dcache_responder #(.s_index(3)) dut (
        .clk(clk), .reset(reset),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    int cycle_cnt = 0;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: cache contents per set and sparse backing memory.
    bit           m_valid [8];
    bit           m_dirty [8];
    logic [8:0]   m_tag   [8];
    logic [127:0] m_line  [8];
    logic [127:0] mem [logic [15:0]];

    int           last_resp_cycle;
    int           last_fill_cyc;
    logic [15:0]  last_wb_addr;
    logic [127:0] last_wb_data;

    function automatic logic [127:0] mem_get(input logic [15:0] a);
        if (!mem.exists(a)) mem[a] = {$urandom, $urandom, $urandom, $urandom};
        return mem[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endtask

    task automatic idle_cycle();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(posedge clk); #1;
        chk("resp_single_pulse", mem_resp, 1'b0);
    endtask

    // One access. 'immediate' means the previous access has just seen its
    // mem_resp in this same cycle, so the DUT spends one RESP cycle first.
    task automatic do_access(input logic [15:0] addr, input bit rd, input bit wr,
                             input logic [1:0] be, input logic [15:0] wd,
                             input bit immediate);
        logic [2:0]   idx;
        logic [8:0]   tg;
        int           w, cyc, wb_cyc, fill_cyc, dw, df, exp_lat;
        logic [15:0]  line_addr, victim_addr;
        bit           hit, dirty_miss, done;
        logic [15:0]  cur;

        idx         = addr[6:4];
        tg          = addr[15:7];
        w           = int'(addr[3:1]);
        line_addr   = {addr[15:4], 4'h0};
        hit         = m_valid[idx] && (m_tag[idx] == tg);
        dirty_miss  = !hit && m_valid[idx] && m_dirty[idx];
        victim_addr = {m_tag[idx], idx, 4'h0};
        dw          = int'($urandom_range(0, 3));
        df          = int'($urandom_range(0, 3));

        mem_address     = addr;
        mem_read        = rd;
        mem_write       = wr;
        mem_byte_enable = be;
        mem_wdata       = wd;

        cyc = 0; wb_cyc = 0; fill_cyc = 0; done = 1'b0;
        while (!done && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            pmem_resp = 1'b0;
            chk("pmem_no_overlap", pmem_read & pmem_write, 1'b0);
            if (mem_resp && !(immediate && cyc == 1)) begin
                done = 1'b1;
            end else if (pmem_write) begin
                if (wb_cyc == 0) begin
                    chk("wb_addr", pmem_address, victim_addr);
                    chk("wb_data", pmem_wdata, m_line[idx]);
                    last_wb_addr = pmem_address;
                    last_wb_data = pmem_wdata;
                end
                if (wb_cyc == dw) begin
                    pmem_resp = 1'b1;
                    mem[victim_addr] = m_line[idx];
                end
                wb_cyc++;
            end else if (pmem_read) begin
                if (fill_cyc == 0) chk("fill_addr", pmem_address, line_addr);
                if (fill_cyc == df) begin
                    pmem_resp  = 1'b1;
                    pmem_rdata = mem_get(line_addr);
                end
                fill_cyc++;
            end
        end
        pmem_resp = 1'b0;

        if (!done) begin
            chk("access_timeout", 1'b0, 1'b1);
        end else begin
            exp_lat = (immediate ? 1 : 0) +
                      (hit ? 1 : ((dirty_miss ? dw + 1 : 0) + df + 3));
            chk("wb_cycles", wb_cyc, dirty_miss ? dw + 1 : 0);
            chk("fill_cycles", fill_cyc, hit ? 0 : df + 1);
            chk("latency", cyc, exp_lat);
        end
        last_resp_cycle = cycle_cnt;
        last_fill_cyc   = fill_cyc;

        if (!hit) begin
            m_line[idx]  = mem_get(line_addr);
            m_tag[idx]   = tg;
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
        end
        if (wr) begin
            cur = m_line[idx][w*16 +: 16];
            if (be[0]) cur[7:0]  = wd[7:0];
            if (be[1]) cur[15:8] = wd[15:8];
            m_line[idx][w*16 +: 16] = cur;
            if (be != 2'b00) m_dirty[idx] = 1'b1;
        end else begin
            chk("rdata", mem_rdata, m_line[idx][w*16 +: 16]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cycle_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] l;
        logic [8:0]   tag_pool [4];
        logic [15:0]  a;
        int           r1;
        bit           seen;
        bit           rd, wr;

        reset = 1'b0; mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
        mem_byte_enable = 2'b00; mem_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;
        last_resp_cycle = 0; last_fill_cyc = 0; last_wb_addr = '0; last_wb_data = '0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_resp", mem_resp, 1'b0);
        chk("rst_mem_rdata", mem_rdata, 16'h0);
        chk("rst_pmem_read", pmem_read, 1'b0);
        chk("rst_pmem_write", pmem_write, 1'b0);
        chk("rst_pmem_address", pmem_address, 16'h0);
        chk("rst_pmem_wdata", pmem_wdata, 128'h0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Cold read with word1 of the fill line = BEEF.
        l = {$urandom, $urandom, $urandom, $urandom};
        l[31:16] = 16'hBEEF;
        mem[16'h0130] = l;
        do_access(16'h0132, 1'b1, 1'b0, 2'b00, 16'h0, 1'b0);
        chk("cold_read_beef", mem_rdata, 16'hBEEF);
        idle_cycle();

        // Byte-write hit, then read back.
        do_access(16'h0132, 1'b0, 1'b1, 2'b01, 16'h1234, 1'b0);
        idle_cycle();
        do_access(16'h0132, 1'b1, 1'b0, 2'b00, 16'h0, 1'b0);
        chk("write_hit_readback", mem_rdata, 16'hBE34);
        idle_cycle();

        // Dirty eviction by a different tag in set 3.
        do_access(16'h0932, 1'b1, 1'b0, 2'b00, 16'h0, 1'b0);
        chk("evict_wb_addr", last_wb_addr, 16'h0130);
        chk("evict_wb_word1", last_wb_data[31:16], 16'hBE34);
        idle_cycle();

        // Back-to-back hits presented right after each resp.
        do_access(16'h0130, 1'b1, 1'b0, 2'b00, 16'h0, 1'b0);
        idle_cycle();
        do_access(16'h0130, 1'b1, 1'b0, 2'b00, 16'h0, 1'b0);
        r1 = last_resp_cycle;
        do_access(16'h0134, 1'b1, 1'b0, 2'b00, 16'h0, 1'b1);
        chk("b2b_resp_gap", last_resp_cycle - r1, 2);
        idle_cycle();

        // Read and write together behave as a write.
        do_access(16'h0130, 1'b1, 1'b1, 2'b11, 16'hA5A5, 1'b0);
        idle_cycle();
        do_access(16'h0130, 1'b1, 1'b0, 2'b00, 16'h0, 1'b0);
        chk("rw_both_readback", mem_rdata, 16'hA5A5);
        idle_cycle();

        // Reset while a fill is outstanding.
        mem_address = 16'h0542; mem_read = 1'b1; mem_write = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            if (pmem_read) seen = 1'b1;
        end
        chk("mid_fill_reached", seen, 1'b1);
        reset = 1'b0; mem_read = 1'b0;
        @(posedge clk); #1;
        model_reset();
        chk("midrst_mem_resp", mem_resp, 1'b0);
        chk("midrst_mem_rdata", mem_rdata, 16'h0);
        chk("midrst_pmem_read", pmem_read, 1'b0);
        chk("midrst_pmem_write", pmem_write, 1'b0);
        chk("midrst_pmem_address", pmem_address, 16'h0);
        chk("midrst_pmem_wdata", pmem_wdata, 128'h0);
        reset = 1'b1;
        pmem_resp = 1'b1;
        pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        chk("stray_resp_no_mem_resp", mem_resp, 1'b0);
        chk("stray_resp_no_pmem_read", pmem_read, 1'b0);
        do_access(16'h0132, 1'b1, 1'b0, 2'b00, 16'h0, 1'b0);
        chk("reread_after_reset_misses", last_fill_cyc != 0, 1'b1);
        idle_cycle();

        // Randomized traffic over a small tag pool to force conflicts.
        for (int i = 0; i < 4; i++) tag_pool[i] = 9'($urandom);
        for (int n = 0; n < 120; n++) begin
            a  = {tag_pool[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
            rd = 1'($urandom);
            wr = 1'($urandom);
            if (!rd && !wr) rd = 1'b1;
            do_access(a, rd, wr, 2'($urandom), 16'($urandom), 1'b0);
            while (($urandom % 2) == 1) begin
                a  = {tag_pool[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
                rd = 1'($urandom);
                wr = !rd || 1'($urandom);
                do_access(a, rd, wr, 2'($urandom), 16'($urandom), 1'b1);
            end
            idle_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
